// File: rtl/uart_bus_slave_pkg.sv
// uart_bus_slave_pkg: register offsets, STATUS bit layout and FSM encodings shared by the UART slave
package uart_bus_slave_pkg;
    // Word offsets (bus_addr[7:1]); byte address 0x00 is DATA, 0x02 is STATUS
    localparam logic [6:0] REG_DATA   = 7'h00;
    localparam logic [6:0] REG_STATUS = 7'h01;

    localparam int ST_RX_VALID  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_IDLE   = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;

    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
endpackage

// File: rtl/uart_bus_slave_rx.sv
// uart_rx_core: synchronised UART receiver with received byte and sticky status flags
//   clk, reset_n     : system clock, asynchronous active-low reset
//   rx_i             : raw asynchronous serial input
//   clr_valid_i      : DATA read this cycle, clears valid_o
//   clr_flags_i      : STATUS read this cycle, clears overrun_o / frame_err_o
//   byte_o, valid_o  : last good byte and its unread flag
//   overrun_o        : a byte was overwritten before being read (sticky)
//   frame_err_o      : a frame ended with a low stop bit (sticky)
module uart_rx_core import uart_bus_slave_pkg::*; #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    input  logic       clr_valid_i,
    input  logic       clr_flags_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       overrun_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state_q;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q, overrun_q, frame_err_q;
    logic          rx_s, cnt_end, done_ok, done_bad;

    assign rx_s     = sync_q[1];
    // Start bit is checked half a bit after the edge; every later sample is one full bit on
    assign cnt_end  = (state_q == RX_START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);
    assign done_ok  = (state_q == RX_STOP) && cnt_end && rx_s;
    assign done_bad = (state_q == RX_STOP) && cnt_end && !rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RX_IDLE;
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx_i};
            prev_q      <= rx_s;
            // A completing byte beats a same-cycle DATA read; overrun only if the old byte stays unread
            valid_q     <= done_ok | (valid_q & ~clr_valid_i);
            overrun_q   <= (done_ok & valid_q & ~clr_valid_i) | (overrun_q & ~clr_flags_i);
            frame_err_q <= done_bad | (frame_err_q & ~clr_flags_i);
            if (done_ok)
                byte_q <= shift_q;
            cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (prev_q && !rx_s)
                        state_q <= RX_START;
                end
                RX_START:
                    if (cnt_end)
                        state_q <= rx_s ? RX_IDLE : RX_DATA;
                RX_DATA:
                    if (cnt_end) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7)
                            state_q <= RX_STOP;
                    end
                RX_STOP:
                    if (cnt_end)
                        state_q <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                default:
                    if (rx_s)
                        state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_o      = byte_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
endmodule

// File: rtl/uart_bus_slave.sv
// uart_bus_slave: 16-bit bus slave exposing a UART with TX FIFO (DATA at 0x00, STATUS at 0x02)
//   clk, reset_n         : system clock, asynchronous active-low reset
//   bus_addr/ds/rw/write : bus request, active while bus_ds != 00
//   bus_read, bus_ack    : registered read data and access-complete handshake
//   uart_rx, uart_tx     : serial in (asynchronous), serial out (idle high)
module uart_bus_slave import uart_bus_slave_pkg::*; #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bus_write,
    output logic [15:0] bus_read,
    input  logic [7:0]  bus_addr,
    input  logic [1:0]  bus_ds,
    input  logic        bus_rw,
    output logic        bus_ack,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int AW   = $clog2(TX_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    bus_state_t    bus_q;
    logic          ack_q;
    logic [15:0]   rdata_q;
    logic [7:0]    mem_q [TX_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CNTW-1:0] count_q, count_d;
    tx_state_t     tx_q;
    logic          line_q;
    logic [8:0]    tx_sh_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;

    logic [7:0]  rx_byte;
    logic        rx_valid, rx_overrun, rx_frame_err;
    logic        access, is_data, is_status, rd_data, rd_status;
    logic        tx_full, tx_idle, push, pop;
    logic [15:0] status, rdata;
    logic        unused_bits;

    // The access happens only on the IDLE->ACK transition, however long bus_ds is held
    assign access    = (bus_q == BUS_IDLE) && (bus_ds != 2'b00);
    assign is_data   = bus_addr[7:1] == REG_DATA;
    assign is_status = bus_addr[7:1] == REG_STATUS;
    assign rd_data   = access && bus_rw && is_data;
    assign rd_status = access && bus_rw && is_status;
    assign tx_full   = count_q == CNTW'(TX_DEPTH);
    assign tx_idle   = (tx_q == TX_IDLE) && (count_q == '0);
    // A push on full is dropped even when a pop frees a slot in the same cycle
    assign push      = access && !bus_rw && is_data && bus_ds[0] && !tx_full;
    assign pop       = (tx_q == TX_IDLE) && (count_q != '0);
    assign count_d   = count_q + CNTW'(push) - CNTW'(pop);
    assign unused_bits = ^{bus_addr[0], bus_write[15:8]};

    always_comb begin
        status = '0;
        status[ST_RX_VALID]  = rx_valid;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_OVERRUN]   = rx_overrun;
        status[ST_FRAME_ERR] = rx_frame_err;
    end

    assign rdata = is_data ? {8'h00, rx_byte} : is_status ? status : 16'h0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_q   <= BUS_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else if (bus_q == BUS_IDLE) begin
            if (access) begin
                bus_q   <= BUS_ACK;
                ack_q   <= 1'b1;
                rdata_q <= bus_rw ? rdata : 16'h0000;
            end
        end else if (bus_ds == 2'b00) begin
            bus_q   <= BUS_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end
    end

    always_ff @(posedge clk)
        if (push)
            mem_q[wptr_q] <= bus_write[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
        end
    end

    // Bit 0 of a frame is the start bit driven on load; tx_sh_q holds data then stop, shifted out LSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q     <= TX_IDLE;
            line_q   <= 1'b1;
            tx_sh_q  <= '1;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else if (tx_q == TX_IDLE) begin
            if (pop) begin
                tx_q     <= TX_BUSY;
                line_q   <= 1'b0;
                tx_sh_q  <= {1'b1, mem_q[rptr_q]};
                tx_cnt_q <= '0;
                tx_bit_q <= '0;
            end
        end else if (tx_cnt_q != FULL_M1) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_q <= '0;
            tx_bit_q <= tx_bit_q + 4'd1;
            line_q   <= tx_sh_q[0];
            tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
            if (tx_bit_q == 4'd9) begin
                tx_q   <= TX_IDLE;
                line_q <= 1'b1;
            end
        end
    end

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_i        (uart_rx),
        .clr_valid_i (rd_data),
        .clr_flags_i (rd_status),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .overrun_o   (rx_overrun),
        .frame_err_o (rx_frame_err)
    );

    assign bus_ack  = ack_q;
    assign bus_read = rdata_q;
    assign uart_tx  = line_q;
endmodule

// File: tb/tb_uart_bus_slave.sv
// tb_uart_bus_slave: scoreboard bench for uart_bus_slave (bus reads and serial TX checked by monitors)
module tb_uart_bus_slave;
    localparam int CPB = 434;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] bus_write = '0;
    logic [15:0] bus_read;
    logic [7:0]  bus_addr = '0;
    logic [1:0]  bus_ds = '0;
    logic        bus_rw = 1'b1;
    logic        bus_ack;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;
    logic [15:0] rd_q [$];
    logic [7:0]  tx_q [$];
    logic        tx_mon_en = 1'b1;
    int          tx_falls = 0;
    logic        ack_prev = 1'b0;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    uart_bus_slave #(.CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus_write (bus_write),
        .bus_read  (bus_read),
        .bus_addr  (bus_addr),
        .bus_ds    (bus_ds),
        .bus_rw    (bus_rw),
        .bus_ack   (bus_ack),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read scoreboard: pop on each rising ack of a read, then hold the value for the rest of ACK
    always @(negedge clk) begin
        if (bus_ack && !ack_prev && bus_rw) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got %0h expected none", bus_read);
            end else begin
                held = rd_q.pop_front();
                chk("read_data", bus_read, held);
            end
        end else if (bus_ack && ack_prev && bus_rw)
            chk("read_hold", bus_read, held);
        ack_prev = bus_ack;
    end

    // TX scoreboard: decode each frame at bit centres and compare with the queued byte
    initial begin : tx_mon
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b = '0;
        forever begin
            @(negedge clk);
            if (prev && !uart_tx) begin
                tx_falls++;
                if (tx_mon_en) begin
                    repeat (CPB / 2) @(negedge clk);
                    chk("tx_start", uart_tx, 0);
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = uart_tx;
                    end
                    repeat (CPB) @(negedge clk);
                    chk("tx_stop", uart_tx, 1);
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", b);
                    end else
                        chk("tx_byte", b, tx_q.pop_front());
                end
            end
            prev = uart_tx;
        end
    end

    task automatic bus_op(input logic r, input logic [7:0] a, input logic [1:0] d,
                          input logic [15:0] w, input int hold, input logic [15:0] exp);
        int n;
        n = 0;
        if (r)
            rd_q.push_back(exp);
        @(posedge clk); #1;
        bus_rw = r; bus_addr = a; bus_write = w; bus_ds = d;
        @(negedge clk);
        chk("ack_early", bus_ack, 0);
        repeat (hold - 1) begin
            @(negedge clk);
            n += int'(bus_ack);
        end
        chk("ack_hold", n, hold - 1);
        @(posedge clk); #1;
        bus_ds = 2'b00;
        repeat (2) @(negedge clk);
        chk("ack_release", bus_ack, 0);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        repeat (3) @(negedge clk);
        chk("rst_ack", bus_ack, 0);
        chk("rst_read", bus_read, 0);
        chk("rst_tx", uart_tx, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0004);

        // One frame, then fill the FIFO behind it while the shifter is busy
        tx_q.push_back(8'h41);
        bus_op(0, 8'h00, 2'b01, 16'h0041, 3, 16'h0);
        bus_op(1, 8'h02, 2'b01, 16'h0, 2, 16'h0000);
        for (int i = 1; i <= 5; i++) begin
            if (i < 5)
                tx_q.push_back(8'(i));
            bus_op(0, 8'h00, 2'b01, 16'(32'hFF00 | i), 2, 16'h0);
            if (i == 3)
                bus_op(1, 8'h02, 2'b01, 16'h0, 2, 16'h0000);
            if (i >= 4)
                bus_op(1, 8'h02, 2'b01, 16'h0, 2, 16'h0002);
        end
        for (int n = 0; n < 30000 && tx_q.size() != 0; n++)
            @(negedge clk);
        chk("tx_drain", tx_q.size(), 0);
        repeat (CPB) @(negedge clk);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0004);

        // Writes that must not push, unmapped reads, odd address aliasing onto STATUS
        bus_op(0, 8'h04, 2'b11, 16'h0099, 2, 16'h0);
        bus_op(0, 8'h00, 2'b10, 16'h7700, 2, 16'h0);
        bus_op(1, 8'h03, 2'b11, 16'h0, 2, 16'h0004);
        bus_op(1, 8'h10, 2'b11, 16'h0, 2, 16'h0000);
        bus_op(1, 8'hFE, 2'b01, 16'h0, 2, 16'h0000);

        // Receiver: good byte, overrun, frame error, glitch
        send(8'hA5, 1'b1);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0005);
        bus_op(1, 8'h00, 2'b11, 16'h0, 2, 16'h00A5);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0004);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        bus_op(1, 8'h00, 2'b11, 16'h0, 2, 16'h0022);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h000C);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0004);
        send(8'h55, 1'b0);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0014);
        bus_op(1, 8'h00, 2'b11, 16'h0, 2, 16'h0022);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (11 * CPB) @(negedge clk);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0004);

        // Long strobe performs one access
        bus_op(1, 8'h02, 2'b11, 16'h0, 20, 16'h0004);

        // Reset in the middle of a frame while an access is acknowledged
        tx_mon_en = 1'b0;
        bus_op(0, 8'h00, 2'b01, 16'h005A, 2, 16'h0);
        repeat (3 * CPB) @(negedge clk);
        rd_q.push_back(16'h0000);
        @(posedge clk); #1;
        bus_rw = 1'b1; bus_addr = 8'h02; bus_ds = 2'b11;
        repeat (3) @(negedge clk);
        chk("ack_before_rst", bus_ack, 1);
        chk("tx_low_before_rst", uart_tx, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_ack_async", bus_ack, 0);
        chk("rst_tx_async", uart_tx, 1);
        chk("rst_read_async", bus_read, 0);
        bus_ds = 2'b00;
        repeat (5) @(negedge clk);
        chk("rst_tx_held", uart_tx, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        snap = tx_falls;
        repeat (12 * CPB) @(negedge clk);
        chk("no_frame_after_rst", tx_falls - snap, 0);
        bus_op(1, 8'h02, 2'b11, 16'h0, 2, 16'h0004);
        chk("rd_queue_empty", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
